seq_pattern_gen: RTL

//  Serial pattern transmitter: the stimulus-side counterpart of the serial sequence detector.
//  - Shifts a programmable PAT_W-bit pattern onto a 1-bit line, MSB first, one bit per clock.
//  - Repeats the pattern a programmed number of times, with a programmable idle gap between copies.
//  - Drives the detector's in_i in loopback benches and on-chip self-test paths.

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_piso.sv | 39 +++
 rtl/seq_pattern_gen.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator.
// Optional feature macro used by seq_pattern_gen: SEQ_GEN_PARITY_EN.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_piso.sv
// Parallel-in / serial-out shift register, MSB first.
// load has priority over shift; q_msb is the bit that will be emitted next.
module seq_piso #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_i,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] d,
    output logic         q_msb
);

    logic [W-1:0] sh_q;
    logic [W-1:0] sh_d;

    // Next shift-register contents: load wins, otherwise shift left by one.
    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = d;
        end else if (shift) begin
            sh_d = {sh_q[W-2:0], 1'b0};
        end
    end

    // Shift-register state.
    // NOTE: this is a few flops of control-path data, not a RAM, so it is reset like any other state.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q_msb = sh_q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB first,
// a programmed number of times, with a programmed idle gap between copies.
// Optional feature macro: SEQ_GEN_PARITY_EN appends an even-parity bit to every copy.
// All outputs are registered; the next-cycle output values are derived from
// the next-state decision, so out_o lines up with state_q == SEND.
module seq_pattern_gen #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic [CNT_W-1:0] repeat_i,
    input  logic [GAP_W-1:0] gap_i,
    output logic             busy_o,
    output logic             out_o,
    output logic             out_valid_o,
    output logic             last_o,
    output logic             done_o
);

    import seq_pkg::*;

`ifdef SEQ_GEN_PARITY_EN
    localparam int BITS = PAT_W + 1;
`else
    localparam int BITS = PAT_W;
`endif
    localparam int IDX_W = $clog2(BITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BITS - 1);

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;   // copies left, including the one on the line
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;   // idle cycles left in the current gap
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;   // index of the bit currently on the line

    logic busy_q, busy_d;
    logic out_q, out_d;
    logic out_valid_q, out_valid_d;
    logic last_q, last_d;
    logic done_q, done_d;

    logic             piso_load;
    logic             piso_shift;
    logic [PAT_W-1:0] piso_d;
    logic             piso_msb;
    logic             next_bit;
    logic             par_slot;
    logic             par_bit;

    // The shift register holds the bits not yet emitted; the bit on the line lives in out_q.
    seq_piso #(.W(PAT_W)) u_piso (
        .clk     (clk),
        .reset_i (reset_i),
        .load    (piso_load),
        .shift   (piso_shift),
        .d       (piso_d),
        .q_msb   (piso_msb)
    );

`ifdef SEQ_GEN_PARITY_EN
    assign par_slot = (bit_idx_q == IDX_W'(PAT_W - 1));
    assign par_bit  = ^pat_q;
`else
    assign par_slot = 1'b0;
    assign par_bit  = 1'b0;
`endif

    // Next-state, counter and registered-output logic.
    // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        gap_d      = gap_q;
        rep_cnt_d  = rep_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        bit_idx_d  = bit_idx_q;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        piso_d     = pat_q << 1;
        next_bit   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    pat_d     = pattern_i;
                    gap_d     = gap_i;
                    rep_cnt_d = repeat_i;
                    bit_idx_d = '0;
                    if (repeat_i != '0) begin
                        state_d   = SEND;
                        piso_load = 1'b1;
                        piso_d    = pattern_i << 1;
                        next_bit  = pattern_i[PAT_W-1];
                    end else begin
                        state_d = DONE;
                    end
                end
            end

            SEND: begin
                if (bit_idx_q != LAST_IDX) begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (par_slot) begin
                        next_bit = par_bit;
                    end else begin
                        next_bit   = piso_msb;
                        piso_shift = 1'b1;
                    end
                end else if (rep_cnt_q > CNT_W'(1)) begin
                    rep_cnt_d = rep_cnt_q - 1'b1;
                    bit_idx_d = '0;
                    if (gap_q != '0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_q;
                    end else begin
                        piso_load = 1'b1;
                        next_bit  = pat_q[PAT_W-1];
                    end
                end else begin
                    rep_cnt_d = '0;
                    state_d   = DONE;
                end
            end

            GAP: begin
                if (gap_cnt_q <= GAP_W'(1)) begin
                    gap_cnt_d = '0;
                    state_d   = SEND;
                    piso_load = 1'b1;
                    next_bit  = pat_q[PAT_W-1];
                end else begin
                    gap_cnt_d = gap_cnt_q - 1'b1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == SEND);
        out_d       = out_valid_d & next_bit;
        last_d      = out_valid_d && (bit_idx_d == LAST_IDX) && (rep_cnt_d == CNT_W'(1));
        done_d      = (state_d == DONE);
        busy_d      = (state_d == SEND) || (state_d == GAP);
    end

    // State, latched fields, counters and output registers.
    // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= IDLE;
            pat_q       <= '0;
            gap_q       <= '0;
            rep_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            bit_idx_q   <= '0;
            busy_q      <= 1'b0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
            last_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pat_q       <= pat_d;
            gap_q       <= gap_d;
            rep_cnt_q   <= rep_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            bit_idx_q   <= bit_idx_d;
            busy_q      <= busy_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            last_q      <= last_d;
            done_q      <= done_d;
        end
    end

    assign busy_o      = busy_q;
    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign last_o      = last_q;
    assign done_o      = done_q;

endmodule
